// File: rtl/control_useq_pkg.sv
// Shared encodings for the microprogrammed datapath sequencer: branch conditions,
// microword field layout, FSM state codes and datapath control-word field positions.
package control_useq_pkg;

  localparam int unsigned COND_W = 3;

  localparam logic [COND_W-1:0] COND_SEQ    = 3'd0;
  localparam logic [COND_W-1:0] COND_JMP    = 3'd1;
  localparam logic [COND_W-1:0] COND_BNEG   = 3'd2;
  localparam logic [COND_W-1:0] COND_BZERO  = 3'd3;
  localparam logic [COND_W-1:0] COND_BMAYOR = 3'd4;
  localparam logic [COND_W-1:0] COND_LOOP   = 3'd5;
  localparam logic [COND_W-1:0] COND_LDC    = 3'd6;
  localparam logic [COND_W-1:0] COND_HALT   = 3'd7;

  // Microword layout, LSB first: {ctrl, cond, target}
  localparam int unsigned TGT_LSB = 0;

  function automatic int unsigned cond_lsb(input int unsigned uaddr_w);
    return TGT_LSB + uaddr_w;
  endfunction

  function automatic int unsigned ctrl_lsb(input int unsigned uaddr_w);
    return cond_lsb(uaddr_w) + COND_W;
  endfunction

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Datapath control-word fields
  localparam int unsigned ALU_MSB  = 15;
  localparam int unsigned ALU_LSB  = 13;
  localparam int unsigned MUXA_LSB = 9;
  localparam int unsigned MUXB_LSB = 5;
  localparam int unsigned REG_LSB  = 1;
  localparam int unsigned W_BIT    = 0;

endpackage

// File: rtl/control_useq_if.sv
// Sequencer-facing bundle: start/flags/program-load inputs and control/status outputs.
interface control_useq_if #(
  parameter int unsigned UADDR_W = 6,
  parameter int unsigned CTRL_W  = 16
);
  localparam int unsigned WORD_W = CTRL_W + 3 + UADDR_W;

  logic               start;
  logic               neg;
  logic               zero;
  logic               mayor;
  logic               prog_we;
  logic [UADDR_W-1:0] prog_addr;
  logic [WORD_W-1:0]  prog_data;
  logic [CTRL_W-1:0]  o_signal;
  logic               busy;
  logic               done;
  logic [UADDR_W-1:0] upc;

  modport master (
    output start, neg, zero, mayor, prog_we, prog_addr, prog_data,
    input  o_signal, busy, done, upc
  );

  modport slave (
    input  start, neg, zero, mayor, prog_we, prog_addr, prog_data,
    output o_signal, busy, done, upc
  );
endinterface

// File: rtl/control_useq_ram.sv
// Writable microcode store: synchronous write, asynchronous read, contents not reset.
module useq_ram #(
  parameter int unsigned AW    = 6,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned DW    = 25
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/control_useq.sv
// Microprogrammed sequencer: walks a writable microcode store one word per cycle,
// branching on datapath flags and a loop counter, with a start/busy/done handshake.
module control_useq
  import control_useq_pkg::*;
#(
  parameter int unsigned UADDR_W = 6,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned CTRL_W  = 16,
  parameter int unsigned LOOP_W  = 4
) (
  input  logic           clk,
  input  logic           rst,
  control_useq_if.slave  bus
);
  localparam int unsigned WORD_W  = CTRL_W + COND_W + UADDR_W;
  localparam int unsigned CND_LSB = cond_lsb(UADDR_W);
  localparam int unsigned CTL_LSB = ctrl_lsb(UADDR_W);

  logic [1:0]         state_q, state_d;
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic [LOOP_W-1:0]  loop_cnt_q, loop_cnt_d;

  logic [WORD_W-1:0]  word;
  logic [CTRL_W-1:0]  ctrl;
  logic [COND_W-1:0]  cond;
  logic [UADDR_W-1:0] tgt;
  logic [UADDR_W-1:0] upc_inc;
  logic               idle;

  assign idle    = (state_q == ST_IDLE);
  assign ctrl    = word[CTL_LSB +: CTRL_W];
  assign cond    = word[CND_LSB +: COND_W];
  assign tgt     = word[TGT_LSB +: UADDR_W];
  // Natural wrap of the UADDR_W-bit add gives DEPTH-1 -> 0
  assign upc_inc = upc_q + 1'b1;

  useq_ram #(
    .AW    (UADDR_W),
    .DEPTH (DEPTH),
    .DW    (WORD_W)
  ) u_ram (
    .clk   (clk),
    .we    (bus.prog_we & idle),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (upc_q),
    .rdata (word)
  );

  always_comb begin
    state_d    = state_q;
    upc_d      = upc_q;
    loop_cnt_d = loop_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          upc_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        upc_d = upc_inc;
        case (cond)
          COND_JMP:    upc_d = tgt;
          COND_BNEG:   if (bus.neg)   upc_d = tgt;
          COND_BZERO:  if (bus.zero)  upc_d = tgt;
          COND_BMAYOR: if (bus.mayor) upc_d = tgt;
          COND_LOOP: begin
            if (loop_cnt_q != '0) begin
              loop_cnt_d = loop_cnt_q - 1'b1;
              upc_d      = tgt;
            end
          end
          COND_LDC:    loop_cnt_d = tgt[LOOP_W-1:0];
          COND_HALT: begin
            upc_d   = upc_q;
            state_d = ST_DONE;
          end
          default: ;
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      upc_q      <= '0;
      loop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      upc_q      <= upc_d;
      loop_cnt_q <= loop_cnt_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them at once
  assign bus.o_signal = (state_q == ST_RUN) ? ctrl : '0;
  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.upc      = upc_q;
endmodule

// File: tb/tb_control_useq.sv
// Scoreboard bench for control_useq: stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares whenever the sequencer is busy or done.
module tb_control_useq;
  import control_useq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_useq_if #(.UADDR_W(6), .CTRL_W(16)) bus ();

  control_useq #(
    .UADDR_W (6),
    .DEPTH   (64),
    .CTRL_W  (16),
    .LOOP_W  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] sig;
    logic [5:0]  upc;
    logic        done;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic er(input logic [15:0] s, input int u);
    exp_t e;
    e.sig = s; e.upc = 6'(u); e.done = 1'b0;
    q.push_back(e);
  endtask

  task automatic ed();
    exp_t e;
    e.sig = 16'h0000; e.upc = '0; e.done = 1'b1;
    q.push_back(e);
  endtask

  task automatic wr(input int a, input logic [15:0] c, input logic [2:0] cd, input int t);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 6'(a);
    bus.prog_data = {c, cd, 6'(t)};
    @(posedge clk); #1;
    bus.prog_we   = 1'b0;
  endtask

  task automatic set_flags(input logic n, input logic z, input logic m);
    bus.neg = n; bus.zero = z; bus.mayor = m;
  endtask

  // hold_start keeps start high through RUN; we_mid attempts a write to addr1 mid-run
  task automatic run(input string name, input bit hold_start, input bit we_mid);
    bit got;
    got = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) bus.start = 1'b0;
    bus.prog_we = we_mid;
    if (we_mid) begin
      bus.prog_addr = 6'd1;
      bus.prog_data = {16'hFFFF, COND_SEQ, 6'd0};
    end
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      bus.prog_we = 1'b0;
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    chk({name, "_leftover"}, q.size(), 32'd0);
    q.delete();
  endtask

  task automatic branch(input string name, input logic [2:0] cd, input bit take);
    wr(0, 16'h0001, cd, 5);
    wr(1, 16'h0002, COND_HALT, 0);
    wr(5, 16'h00FF, COND_HALT, 0);
    er(16'h0001, 0);
    if (take) er(16'h00FF, 5);
    else      er(16'h0002, 1);
    ed();
    run(name, 1'b0, 1'b0);
  endtask

  // Monitor: one comparison per RUN/DONE cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.busy || bus.done)) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output sig=%h upc=%0d busy=%b done=%b required=idle",
                   bus.o_signal, bus.upc, bus.busy, bus.done);
        end else begin
          e = q.pop_front();
          if (bus.o_signal !== e.sig || bus.busy !== !e.done || bus.done !== e.done ||
              (!e.done && bus.upc !== e.upc)) begin
            failures++;
            $display("FAIL cycle actual sig=%h upc=%0d busy=%b done=%b required sig=%h upc=%0d busy=%b done=%b",
                     bus.o_signal, bus.upc, bus.busy, bus.done, e.sig, e.upc, !e.done, e.done);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    set_flags(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_signal", 32'(bus.o_signal), 32'h0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_upc", 32'(bus.upc), 32'd0);
    rst = 1'b0;

    // Straight-line program
    wr(0, 16'h4200, COND_SEQ, 0);
    wr(1, 16'h8C0D, COND_SEQ, 0);
    wr(2, 16'h0000, COND_HALT, 0);
    chk("idle_o_signal", 32'(bus.o_signal), 32'h0);
    er(16'h4200, 0); er(16'h8C0D, 1); er(16'h0000, 2); ed();
    run("seq", 1'b0, 1'b0);

    // Conditional branches, other flags set opposite
    set_flags(1'b1, 1'b0, 1'b0); branch("bneg_t", COND_BNEG, 1'b1);
    set_flags(1'b0, 1'b1, 1'b1); branch("bneg_n", COND_BNEG, 1'b0);
    set_flags(1'b0, 1'b1, 1'b0); branch("bzero_t", COND_BZERO, 1'b1);
    set_flags(1'b1, 1'b0, 1'b1); branch("bzero_n", COND_BZERO, 1'b0);
    set_flags(1'b0, 1'b0, 1'b1); branch("bmayor_t", COND_BMAYOR, 1'b1);
    set_flags(1'b1, 1'b1, 1'b0); branch("bmayor_n", COND_BMAYOR, 1'b0);
    set_flags(1'b0, 1'b0, 1'b0);

    // Counted loop: body at addr1 runs 1 + 3 times
    wr(0, 16'h0030, COND_LDC, 3);
    wr(1, 16'h0010, COND_SEQ, 0);
    wr(2, 16'h0020, COND_LOOP, 1);
    wr(3, 16'h0040, COND_HALT, 0);
    er(16'h0030, 0);
    for (int i = 0; i < 4; i++) begin
      er(16'h0010, 1); er(16'h0020, 2);
    end
    er(16'h0040, 3); ed();
    run("loop", 1'b0, 1'b0);

    // Wrap 63 -> 0 with start held; LOOP at 0 falls through first (cnt=0), jumps second
    wr(0, 16'h00A0, COND_LOOP, 5);
    wr(1, 16'h00A1, COND_LDC, 1);
    wr(2, 16'h00A2, COND_JMP, 63);
    wr(63, 16'h0063, COND_SEQ, 0);
    wr(5, 16'h0055, COND_HALT, 0);
    er(16'h00A0, 0); er(16'h00A1, 1); er(16'h00A2, 2); er(16'h0063, 63);
    er(16'h00A0, 0); er(16'h0055, 5); ed();
    run("wrap", 1'b1, 1'b0);

    // Writes dropped while running, accepted in IDLE together with start
    wr(0, 16'h0A0A, COND_SEQ, 0);
    wr(1, 16'h1111, COND_SEQ, 0);
    wr(2, 16'h2222, COND_HALT, 0);
    er(16'h0A0A, 0); er(16'h1111, 1); er(16'h2222, 2); ed();
    run("we_busy", 1'b0, 1'b1);
    er(16'h0A0A, 0); er(16'h1111, 1); er(16'h2222, 2); ed();
    run("we_rerun", 1'b0, 1'b0);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 6'd1;
    bus.prog_data = {16'hFFFF, COND_SEQ, 6'd0};
    er(16'h0A0A, 0); er(16'hFFFF, 1); er(16'h2222, 2); ed();
    run("we_idle", 1'b0, 1'b0);

    // Reset on the second RUN cycle
    wr(0, 16'h1234, COND_SEQ, 0);
    wr(1, 16'h5678, COND_SEQ, 0);
    wr(2, 16'h9ABC, COND_SEQ, 0);
    wr(3, 16'h0000, COND_HALT, 0);
    er(16'h1234, 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstrun_o_signal", 32'(bus.o_signal), 32'h0);
    chk("rstrun_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstrun_done", {31'd0, bus.done}, 32'd0);
    chk("rstrun_upc", 32'(bus.upc), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstrun_leftover", q.size(), 32'd0);
    q.delete();
    er(16'h1234, 0); er(16'h5678, 1); er(16'h9ABC, 2); er(16'h0000, 3); ed();
    run("restart", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
